divider: RTL and testbench



---
 rtl/divider.sv | 91 +++++++++
 tb/tb_divider.sv | 128 ++++++++++++
 2 files changed

// File: rtl/divider.sv
// divider: restoring fixed-point divider q_out=a_in/b_in (clk,sclr,start,a_in,b_in -> busy,dvz,ovf,valid,q_out); DIVIDER_ROUND_EN adds round-half-up
module divider #(
  parameter int WIDTH = 10,
  parameter int FRAC = 6
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             dvz,
  output logic             ovf,
  output logic             valid,
  output logic [WIDTH-1:0] q_out
);
  localparam int N = WIDTH + FRAC;
`ifdef DIVIDER_ROUND_EN
  localparam int ITER = N + 1;
`else
  localparam int ITER = N;
`endif
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] b_reg, rem, r_sh, r_nx;
  logic [ITER-1:0] dvd, quo;
  logic [CW-1:0] cnt;
  logic ge;
  logic [N:0] q_fin;
  always_comb begin
    r_sh = {rem[WIDTH-2:0], dvd[ITER-1]};
    ge = rem[WIDTH-1] | (r_sh >= b_reg);
    r_nx = ge ? r_sh - b_reg : r_sh;
  end
`ifdef DIVIDER_ROUND_EN
  assign q_fin = {1'b0, quo[ITER-1:1]} + {{N{1'b0}}, quo[0]};
`else
  assign q_fin = {1'b0, quo};
`endif
  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
      busy <= 1'b0;
      dvz <= 1'b0;
      ovf <= 1'b0;
      valid <= 1'b0;
      q_out <= '0;
      b_reg <= '0;
      dvd <= '0;
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            b_reg <= b_in;
            dvd <= {a_in, {(ITER-WIDTH){1'b0}}};
            quo <= '0;
            rem <= '0;
            cnt <= CW'(ITER);
            dvz <= (b_in == '0);
            ovf <= 1'b0;
            q_out <= '0;
            busy <= (b_in != '0);
            state <= (b_in == '0) ? DONE : CALC;
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          quo <= {quo[ITER-2:0], ge};
          rem <= r_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b1;
          ovf <= |q_fin[N:WIDTH];
          q_out <= |q_fin[N:WIDTH] ? '1 : q_fin[WIDTH-1:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized self-checking bench for divider against an arithmetic quotient model
module tb_divider;
  localparam int W = 10;
  localparam int F = 6;
`ifdef DIVIDER_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int ITER = W + F + RND;
  logic clk = 1'b0;
  logic sclr, start, busy, dvz, ovf, valid;
  logic [W-1:0] a_in, b_in, q_out;
  int checks = 0;
  int failures = 0;
  divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .sclr(sclr), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .dvz(dvz), .ovf(ovf), .valid(valid), .q_out(q_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    longint full;
    logic [W-1:0] eq;
    logic eo, ed;
    int lat, bc;
    ed = (b == 0);
    if (ed) full = 0;
    else if (RND == 1) full = ((longint'(a) << (F + 1)) + longint'(b)) / (2 * longint'(b));
    else full = (longint'(a) << F) / longint'(b);
    eo = full > longint'(2 ** W - 1);
    eq = eo ? '1 : W'(full);
    @(negedge clk);
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
    bc = int'(busy);
    lat = 0;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      if (poke && c == 5) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (valid) lat = c;
      else bc += int'(busy);
    end
    check("latency", lat, ed ? 1 : ITER + 1);
    check("busy_cycles", bc, ed ? 0 : ITER);
    check("q_out", q_out, eq);
    check("dvz", dvz, ed);
    check("ovf", ovf, eo);
    @(posedge clk);
    #1;
    check("valid_pulse", valid, 0);
    check("q_hold", q_out, eq);
  endtask
  initial begin
    int vcnt;
    logic [W-1:0] ra, rb;
    sclr = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_q", q_out, 0);
    check("rst_dvz", dvz, 0);
    check("rst_ovf", ovf, 0);
    sclr = 1'b0;
    do_op(10'd80, 10'd32, 0);
    do_op(10'd64, 10'd192, 0);
    do_op(10'd128, 10'd192, 0);
    do_op(10'd80, 10'd0, 0);
    do_op(10'd1023, 10'd1, 0);
    do_op(10'd100, 10'd50, 1);
    do_op(10'd1023, 10'd1023, 0);
    do_op(10'd0, 10'd5, 0);
    do_op(10'd1, 10'd1023, 0);
    do_op(10'd700, 10'd300, 1);
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op(ra, rb, 1'($urandom_range(0, 1)));
    end
    do_op(10'd1023, 10'd1, 0);
    @(negedge clk);
    a_in = 10'd500;
    b_in = 10'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sclr = 1'b1;
    @(posedge clk);
    #1;
    sclr = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_q", q_out, 0);
    check("abort_dvz", dvz, 0);
    check("abort_ovf", ovf, 0);
    vcnt = 0;
    for (int c = 0; c < ITER + 5; c++) begin
      @(posedge clk);
      #1;
      vcnt += int'(valid) + int'(busy);
    end
    check("abort_quiet", vcnt, 0);
    do_op(10'd320, 10'd64, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
